// File: rtl/rf_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter_pkg
//   Shared definitions for the register-file write-back arbiter:
//     - register-address and data widths
//     - RegWrite encodings (IDLE / WRITE)
//     - requester index constants (ALU, load, mul/div)
//     - write-counter limit and a saturating increment helper
// -----------------------------------------------------------------------------
package rf_write_arbiter_pkg;

  // Register-file geometry.
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  // Register-file write-enable encodings as seen on the RegWrite port.
  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_WRITE = 2'b01
  } regwrite_e;

  // Requester slots on the write-back bus.
  localparam int REQ_ALU    = 0;
  localparam int REQ_LOAD   = 1;
  localparam int REQ_MULDIV = 2;

  // Write counter.
  localparam int          CNT_W   = 16;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Increment that sticks at the top value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage : rf_write_arbiter_pkg

// File: rtl/rf_write_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin picker. Starting at index ptr and wrapping from
//   NREQ-1 back to 0, the first requester with valid set wins. The result is a
//   one-hot grant vector (all zero when nothing is valid).
//
// Ports
//   valid [NREQ-1:0]  per-requester request
//   ptr   [PW-1:0]    index that has highest priority this cycle (< NREQ)
//   grant [NREQ-1:0]  one-hot winner
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  // Two fixed-order passes replace a modular index: the first pass only
  // considers indices at or above ptr, the second covers the wrapped part
  // below ptr. The first hit in either pass wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which is what keeps a latch from being inferred.
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && valid[i] && (PW'(i) >= ptr)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule : rr_picker

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//   Arbitrates NREQ write-back requesters (0 ALU, 1 load, 2 mul/div) onto the
//   single register-file write port. One requester is accepted per cycle with
//   round-robin fairness; the accepted register/data pair is registered and
//   presented to the register file on the following cycle. RegWrite, WriteReg
//   and WriteData connect directly to the RegisterFile ports of the same name.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         synchronous active-high reset
//   req_valid   [NREQ-1:0]     per-requester write request
//   req_reg     [NREQ*5-1:0]   destination register, slice i = [5i+4:5i]
//   req_data    [NREQ*32-1:0]  write data, slice i = [32i+31:32i]
//   req_ready   [NREQ-1:0]     one-hot accept; transfer = valid & ready
//   wb_stall    suspend all grants while high
//   RegWrite    [1:0]  2'b01 write, 2'b00 idle
//   WriteReg    [4:0]  register-file write address
//   WriteData   [31:0] register-file write data
//   wr_count    [15:0] saturating count of writes issued
//
// Configuration
//   RF_ARB_ZERO_GUARD_EN  when defined, requests targeting register 0 are
//                         accepted normally but never produce a write and are
//                         not counted.
// -----------------------------------------------------------------------------
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*REG_W-1:0]  req_reg,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   wb_stall,
  output logic [1:0]             RegWrite,
  output logic [REG_W-1:0]       WriteReg,
  output logic [DATA_W-1:0]      WriteData,
  output logic [CNT_W-1:0]       wr_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     ptr_nxt;
  logic [NREQ-1:0]   pick;
  logic [NREQ-1:0]   grant;
  logic              transfer;
  logic [REG_W-1:0]  sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic              do_write;

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (pick)
  );

  // Grants depend only on valid, ptr, stall and reset -- never on the
  // register or data payloads.
  assign grant     = (rst || wb_stall) ? '0 : pick;
  assign req_ready = grant;
  assign transfer  = |grant;

  // Payload mux and next pointer, selected by the one-hot grant.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    ptr_nxt  = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_reg  = req_reg[i*REG_W +: REG_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
        ptr_nxt  = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // An accepted request turns into a register-file write unless the guard
  // suppresses writes to register 0.
`ifdef RF_ARB_ZERO_GUARD_EN
  assign do_write = transfer && (sel_reg != '0);
`else
  assign do_write = transfer;
`endif

  // ---------------------------------------------------------------------------
  // Registered write port and counter
  // ---------------------------------------------------------------------------
  regwrite_e         regwrite_q;
  logic [REG_W-1:0]  wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order within the block.
  // NOTE: the datapath registers are reset too, because the write address and
  // data must read as zero after reset rather than hold stale contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      regwrite_q <= RW_IDLE;
      wreg_q     <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
    end else begin
      ptr_q      <= ptr_nxt;
      regwrite_q <= do_write ? RW_WRITE : RW_IDLE;
      if (transfer) begin
        wreg_q  <= sel_reg;
        wdata_q <= sel_data;
      end
      // Counted on the same edge that raises RegWrite, so wr_count already
      // includes a write during the cycle that write is on the port.
      if (do_write) begin
        count_q <= sat_inc(count_q);
      end
    end
  end

  assign RegWrite  = regwrite_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;
  assign wr_count  = count_q;

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
//   Directed bench for rf_write_arbiter (NREQ = 3) with hand-computed
//   expectations: reset, single request, contention, stall, reset in the
//   middle of traffic, register-0 handling and counter saturation.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wb_stall;
  logic [1:0]  RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(.NREQ(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wb_stall  (wb_stall),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are read 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  logic [2:0] exp_ready;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;
    wb_stall  = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    req_valid = 3'b111;
    #1;
    check("rst_ready",     {29'd0, req_ready}, 32'h0);
    check("rst_regwrite",  {30'd0, RegWrite},  32'h0);
    check("rst_writereg",  {27'd0, WriteReg},  32'h0);
    check("rst_writedata", WriteData,          32'h0);
    check("rst_count",     {16'd0, wr_count},  32'h0);
    tick();
    rst       = 1'b0;
    req_valid = '0;

    // ---------------- single request ----------------
    req_valid = 3'b001;
    req_reg   = {5'd0, 5'd0, 5'd5};
    req_data  = {32'h0, 32'h0, 32'hDEADBEEF};
    #1;
    check("single_ready", {29'd0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    check("single_regwrite",  {30'd0, RegWrite}, 32'h1);
    check("single_writereg",  {27'd0, WriteReg}, 32'd5);
    check("single_writedata", WriteData,         32'hDEADBEEF);
    check("single_count",     {16'd0, wr_count}, 32'd1);
    tick();
    check("idle_regwrite", {30'd0, RegWrite}, 32'h0);
    check("idle_hold_reg", {27'd0, WriteReg}, 32'd5);
    check("idle_hold_data", WriteData,        32'hDEADBEEF);

    // ---------------- contention from reset ----------------
    do_reset();
    req_reg   = {5'd12, 5'd11, 5'd10};
    req_data  = {32'd102, 32'd101, 32'd100};
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_ready = 3'b001 << (k % 3);
      #1;
      check($sformatf("rr_ready_%0d", k), {29'd0, req_ready}, {29'd0, exp_ready});
      tick();
      check($sformatf("rr_regwrite_%0d", k), {30'd0, RegWrite}, 32'h1);
      check($sformatf("rr_writereg_%0d", k), {27'd0, WriteReg}, 32'(10 + k % 3));
      check($sformatf("rr_writedata_%0d", k), WriteData, 32'(100 + k % 3));
    end
    req_valid = '0;
    check("rr_count", {16'd0, wr_count}, 32'd6);

    // ---------------- stall (ptr is 0 here) ----------------
    req_valid = 3'b010;
    wb_stall  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall_ready_%0d", k), {29'd0, req_ready}, 32'h0);
      tick();
      check($sformatf("stall_regwrite_%0d", k), {30'd0, RegWrite}, 32'h0);
    end
    check("stall_count", {16'd0, wr_count}, 32'd6);
    wb_stall = 1'b0;
    #1;
    check("unstall_ready", {29'd0, req_ready}, 32'h2);
    tick();
    req_valid = '0;
    check("unstall_regwrite", {30'd0, RegWrite}, 32'h1);
    check("unstall_writereg", {27'd0, WriteReg}, 32'd11);
    check("unstall_count",    {16'd0, wr_count}, 32'd7);
    // ptr is now 2: a 3'b011 request must go to 0 (wrap), not 1.
    req_valid = 3'b011;
    #1;
    check("wrap_ready", {29'd0, req_ready}, 32'h1);
    req_valid = '0;
    tick();

    // ---------------- reset in the middle of traffic ----------------
    do_reset();
    req_valid = 3'b111;
    tick();           // cycle 1: grant 0
    tick();           // cycle 2: grant 1, its write is registered for cycle 3
    check("midrst_pre_regwrite", {30'd0, RegWrite}, 32'h1);
    rst = 1'b1;       // cycle 3
    #1;
    check("midrst_ready", {29'd0, req_ready}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_regwrite", {30'd0, RegWrite}, 32'h0);
    check("midrst_count",    {16'd0, wr_count}, 32'h0);
    check("midrst_ready0",   {29'd0, req_ready}, 32'h1);
    tick();
    check("midrst_first_reg", {27'd0, WriteReg}, 32'd10);
    check("midrst_first_cnt", {16'd0, wr_count}, 32'd1);
    req_valid = '0;

    // ---------------- register 0 (ptr is 1 here) ----------------
    req_valid = 3'b001;
    req_reg   = {5'd0, 5'd0, 5'd0};
    req_data  = {32'h0, 32'h0, 32'h1};
    #1;
    check("zero_ready", {29'd0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
`ifdef RF_ARB_ZERO_GUARD_EN
    check("zero_regwrite", {30'd0, RegWrite}, 32'h0);
    check("zero_count",    {16'd0, wr_count}, 32'd1);
`else
    check("zero_regwrite",  {30'd0, RegWrite}, 32'h1);
    check("zero_writereg",  {27'd0, WriteReg}, 32'd0);
    check("zero_writedata", WriteData,         32'h1);
    check("zero_count",     {16'd0, wr_count}, 32'd2);
`endif

    // ---------------- counter saturation ----------------
    do_reset();
    req_reg   = {5'd0, 5'd0, 5'd7};
    req_valid = 3'b001;
    for (int k = 0; k < 65534; k++) tick();
    check("sat_fffe", {16'd0, wr_count}, 32'h0000FFFE);
    tick();
    check("sat_ffff", {16'd0, wr_count}, 32'h0000FFFF);
    tick();
    tick();
    check("sat_hold",     {16'd0, wr_count}, 32'h0000FFFF);
    check("sat_regwrite", {30'd0, RegWrite}, 32'h1);
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rf_write_arbiter
